// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_valid,
  output logic       o_tx_ready,
  input  logic       i_ps2_clk_in,
  input  logic       i_ps2_data_in,
  output logic       o_ps2_clk_oe,
  output logic       o_ps2_data_oe,
  output logic       o_tx_done,
  output logic       o_tx_error
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FLT_W = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t             r_state;
  logic [1:0]         r_clk_sync;
  logic [1:0]         r_data_sync;
  logic               r_clk_filt;
  logic               r_clk_filt_d;
  logic [FLT_W-1:0]   r_filt_cnt;
  logic [7:0]         r_data;
  logic               r_parity;
  logic [3:0]         r_bit;
  logic [INH_W-1:0]   r_inh_cnt;
  logic [TMO_W-1:0]   r_tmo_cnt;
  logic               r_nack;

  logic               w_clk_s;
  logic               w_data_s;
  logic               w_fall;
  logic               w_in_xfer;
  logic               w_timeout;

  assign w_clk_s   = r_clk_sync[1];
  assign w_data_s  = r_data_sync[1];
  assign w_fall    = r_clk_filt_d & ~r_clk_filt;
  assign w_in_xfer = (r_state == S_REQ) || (r_state == S_SEND) ||
                     (r_state == S_ACK) || (r_state == S_WAIT_IDLE);
  assign w_timeout = (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // Two-flop synchronizers for both sensed pins; idle lines read high
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], i_ps2_clk_in};
      r_data_sync <= {r_data_sync[0], i_ps2_data_in};
    end
  end

  // Glitch filter: accept a new clock level only after FILTER_LEN equal samples
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_clk_filt   <= 1'b1;
      r_clk_filt_d <= 1'b1;
      r_filt_cnt   <= '0;
    end else begin
      r_clk_filt_d <= r_clk_filt;
      if (w_clk_s == r_clk_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FLT_W'(FILTER_LEN - 1)) begin
        r_clk_filt <= w_clk_s;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + FLT_W'(1);
      end
    end
  end

  // Transfer FSM: inhibit, request-to-send, shift out on falls, collect ack
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_data        <= '0;
      r_parity      <= 1'b0;
      r_bit         <= '0;
      r_inh_cnt     <= '0;
      r_tmo_cnt     <= '0;
      r_nack        <= 1'b0;
      o_tx_ready    <= 1'b1;
      o_ps2_clk_oe  <= 1'b0;
      o_ps2_data_oe <= 1'b0;
      o_tx_done     <= 1'b0;
      o_tx_error    <= 1'b0;
    end else begin
      o_tx_done  <= 1'b0;
      o_tx_error <= 1'b0;
      if (w_in_xfer && w_timeout) begin
        // Device stopped clocking: give the bus back and report failure
        o_ps2_clk_oe  <= 1'b0;
        o_ps2_data_oe <= 1'b0;
        o_tx_error    <= 1'b1;
        o_tx_ready    <= 1'b1;
        r_state       <= S_IDLE;
      end else begin
        if (w_in_xfer) begin
          r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
        case (r_state)
          S_IDLE: begin
            o_ps2_clk_oe  <= 1'b0;
            o_ps2_data_oe <= 1'b0;
            if (i_tx_valid && o_tx_ready) begin
              r_data       <= i_tx_data;
              r_parity     <= ~^i_tx_data;
              o_tx_ready   <= 1'b0;
              o_ps2_clk_oe <= 1'b1;
              r_inh_cnt    <= '0;
              r_state      <= S_INHIBIT;
            end
          end
          S_INHIBIT: begin
            if (r_inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
              o_ps2_clk_oe  <= 1'b0;
              o_ps2_data_oe <= 1'b1;
              r_tmo_cnt     <= '0;
              r_bit         <= '0;
              r_state       <= S_REQ;
            end else begin
              // Start bit goes down one cycle before the clock is released
              if (r_inh_cnt == INH_W'(INHIBIT_CYCLES - 2)) begin
                o_ps2_data_oe <= 1'b1;
              end
              r_inh_cnt <= r_inh_cnt + INH_W'(1);
            end
          end
          S_REQ: begin
            o_ps2_clk_oe  <= 1'b0;
            o_ps2_data_oe <= 1'b1;
            r_state       <= S_SEND;
          end
          S_SEND: begin
            if (w_fall) begin
              if (r_bit == 4'd9) begin
                o_ps2_data_oe <= 1'b0;
                r_state       <= S_ACK;
              end else if (r_bit == 4'd8) begin
                o_ps2_data_oe <= ~r_parity;
              end else begin
                o_ps2_data_oe <= ~r_data[r_bit[2:0]];
              end
              r_bit <= r_bit + 4'd1;
            end
          end
          S_ACK: begin
            if (w_fall) begin
              r_nack  <= w_data_s;
              r_state <= S_WAIT_IDLE;
            end
          end
          S_WAIT_IDLE: begin
            if (r_clk_filt && w_data_s) begin
              o_tx_done  <= ~r_nack;
              o_tx_error <= r_nack;
              o_tx_ready <= 1'b1;
              r_state    <= S_IDLE;
            end
          end
          default: begin
            o_ps2_clk_oe  <= 1'b0;
            o_ps2_data_oe <= 1'b0;
            o_tx_ready    <= 1'b1;
            r_state       <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
